multi_pulse_generator: RTL and testbench

- NUM_CH independent pulse channels sharing one clock. Each channel has a runtime-programmable delay, width, gap and mode.
- A trigger edge produces a delayed single pulse or a pulse train. Gate mode also supports level-held triggering.
- Drives strobes, sample enables and test stimulus in the 50 MHz fabric. One count is one clk cycle (20 ns).

---
 rtl/multi_pulse_generator.sv | 149 ++++++++++++++
 tb/tb_multi_pulse_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_generator.sv
// Multi-channel programmable pulse generator: per-channel delay/width/gap with
// one-shot, retriggerable, periodic and gate modes. Each channel is an independent FSM.
module multi_pulse_generator #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       trig,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic [CNT_W*NUM_CH-1:0] delay,
  input  logic [CNT_W*NUM_CH-1:0] width,
  input  logic [CNT_W*NUM_CH-1:0] gap,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       busy
);

  localparam logic [1:0] M_RETRIG   = 2'b01;
  localparam logic [1:0] M_PERIODIC = 2'b10;
  localparam logic [1:0] M_GATE     = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_ACTIVE, S_GAP, S_HOLD} state_t;

  logic [NUM_CH-1:0] r_trig_q;

  // History resets to ones so a trigger already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) r_trig_q <= '1;
    else        r_trig_q <= trig;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           r_state;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_delay, r_width, r_gap, r_cnt;
    logic             r_pulse, r_busy;

    logic             w_trig, w_edge, w_accept;
    logic [1:0]       w_mode;
    logic [CNT_W-1:0] w_delay, w_width, w_gap;
    state_t           w_start;

    assign w_trig  = trig[c];
    assign w_edge  = trig[c] & ~r_trig_q[c];
    assign w_mode  = mode[2*c +: 2];
    assign w_delay = delay[c*CNT_W +: CNT_W];
    assign w_width = width[c*CNT_W +: CNT_W];
    assign w_gap   = gap[c*CNT_W +: CNT_W];
    assign w_start = (w_delay != '0) ? S_DELAY : ((w_width != '0) ? S_ACTIVE : S_IDLE);
    assign w_accept = w_edge && ((r_state == S_IDLE) ||
                      ((r_mode == M_RETRIG) && ((r_state == S_DELAY) || (r_state == S_ACTIVE))));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_mode  <= '0;
        r_delay <= '0;
        r_width <= '0;
        r_gap   <= '0;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_accept) begin
        // Fresh start or retrigger: config is frozen here for the whole sequence.
        r_mode  <= w_mode;
        r_delay <= w_delay;
        r_width <= w_width;
        r_gap   <= w_gap;
        r_state <= w_start;
        r_cnt   <= (w_start == S_IDLE) ? '0 : CNT_ONE;
        r_pulse <= (w_start == S_ACTIVE);
        r_busy  <= (w_start != S_IDLE);
      end else begin
        case (r_state)
          S_DELAY: begin
            if (((r_mode == M_GATE) && !w_trig) || ((r_cnt == r_delay) && (r_width == '0))) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_pulse <= 1'b0;
              r_busy  <= 1'b0;
            end else if (r_cnt == r_delay) begin
              r_state <= S_ACTIVE;
              r_cnt   <= CNT_ONE;
              r_pulse <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_ACTIVE: begin
            if ((r_mode == M_GATE) && !w_trig) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_pulse <= 1'b0;
              r_busy  <= 1'b0;
            end else if (r_cnt == r_width) begin
              if (r_mode == M_GATE) begin
                r_state <= S_HOLD;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
              end else if ((r_mode == M_PERIODIC) && w_trig) begin
                // Zero gap chains straight into the next pulse, keeping the output high.
                r_state <= (r_gap == '0) ? S_ACTIVE : S_GAP;
                r_cnt   <= CNT_ONE;
                r_pulse <= (r_gap == '0);
              end else begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_GAP: begin
            if (!w_trig) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (r_cnt == r_gap) begin
              r_state <= S_ACTIVE;
              r_cnt   <= CNT_ONE;
              r_pulse <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_HOLD: begin
            if (!w_trig) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end

    assign pulse[c] = r_pulse;
    assign busy[c]  = r_busy;
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Bench for multi_pulse_generator: directed scenarios then random traffic, all checked
// against a timeline model that derives pulse/busy from the cycle offset since each start.
module tb_multi_pulse_generator;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       trig;
  logic [2*NUM_CH-1:0]     mode;
  logic [CNT_W*NUM_CH-1:0] delay, width, gap;
  logic [NUM_CH-1:0]       pulse, busy;

  multi_pulse_generator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .mode(mode),
    .delay(delay), .width(width), .gap(gap), .pulse(pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: each active channel is described by its start cycle and latched config.
  int cyc = 0;
  bit act[NUM_CH];
  bit tprev[NUM_CH];
  int t0[NUM_CH], md[NUM_CH], dl[NUM_CH], wd[NUM_CH], gp[NUM_CH];
  logic [NUM_CH-1:0] exp_pulse, exp_busy;

  task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit t, e;
      int rel;
      t = trig[c];
      if (!rst_n) begin
        act[c] = 0;
        tprev[c] = 1;
      end else begin
        e = t & ~tprev[c];
        if (e && (!act[c] || md[c] == 1)) begin
          act[c] = 1;
          t0[c] = cyc;
          md[c] = int'(mode[2*c +: 2]);
          dl[c] = int'(delay[c*CNT_W +: CNT_W]);
          wd[c] = int'(width[c*CNT_W +: CNT_W]);
          gp[c] = int'(gap[c*CNT_W +: CNT_W]);
          if (dl[c] == 0 && wd[c] == 0) act[c] = 0;
        end else if (act[c]) begin
          rel = cyc - t0[c];
          case (md[c])
            0, 1: if (rel >= dl[c] + wd[c]) act[c] = 0;
            2: begin
              if (wd[c] == 0) begin
                if (rel >= dl[c]) act[c] = 0;
              end else if (rel >= dl[c] + wd[c] && !t &&
                           ((rel - dl[c] - wd[c]) % (wd[c] + gp[c])) <= gp[c]) begin
                act[c] = 0;
              end
            end
            default: if (!t || (wd[c] == 0 && rel >= dl[c])) act[c] = 0;
          endcase
        end
        tprev[c] = t;
      end
      exp_busy[c] = act[c];
      exp_pulse[c] = 1'b0;
      if (act[c] && wd[c] > 0) begin
        rel = cyc - t0[c];
        if (md[c] == 2) exp_pulse[c] = (rel >= dl[c]) && (((rel - dl[c]) % (wd[c] + gp[c])) < wd[c]);
        else            exp_pulse[c] = (rel >= dl[c]) && (rel < dl[c] + wd[c]);
      end
    end
    cyc++;
  endtask

  // One clock: model the coming edge from the current inputs, then check at the falling edge.
  task automatic step();
    model_step();
    @(negedge clk);
    chk("pulse", pulse, exp_pulse);
    chk("busy", busy, exp_busy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input int c, input int m, input int d, input int w, input int g);
    mode[2*c +: 2]        = 2'(m);
    delay[c*CNT_W +: CNT_W] = CNT_W'(d);
    width[c*CNT_W +: CNT_W] = CNT_W'(w);
    gap[c*CNT_W +: CNT_W]   = CNT_W'(g);
  endtask

  initial begin
    rst_n = 1'b0; trig = '0; mode = '0; delay = '0; width = '0; gap = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      act[c] = 0; tprev[c] = 1; t0[c] = 0; md[c] = 0; dl[c] = 0; wd[c] = 0; gp[c] = 0;
    end

    // Reset with trig[0] high, then release: no edge, no pulse.
    trig = 4'b0001;
    run(2);
    chk("rst_pulse", pulse, 4'b0000);
    chk("rst_busy", busy, 4'b0000);
    rst_n = 1'b1;
    run(3);
    chk("held_trig_busy", busy, 4'b0000);
    trig = '0;
    run(2);
    cfg(0, 0, 0, 10, 0);
    trig = 4'b0001;
    step();
    chk("d0_rise", pulse, 4'b0001);
    run(9);
    chk("d0_last_high", pulse, 4'b0001);
    step();
    chk("d0_fall", pulse, 4'b0000);
    trig = '0;
    run(3);

    // One-shot with a second edge while busy, then width=0.
    cfg(0, 0, 3, 5, 0);
    trig = 4'b0001; step();
    trig = 4'b0000; step();
    trig = 4'b0001; step();
    trig = 4'b0000; run(10);
    cfg(0, 0, 2, 0, 0);
    trig = 4'b0001; run(4);
    trig = 4'b0000; run(2);

    // Retriggerable, re-edge at E+5.
    cfg(0, 1, 0, 8, 0);
    trig = 4'b0001; step();
    trig = 4'b0000; run(4);
    trig = 4'b0001; step();
    trig = 4'b0000; run(10);

    // Periodic: 11000 pattern, drop mid-pulse, then gap=0.
    cfg(0, 2, 0, 2, 3);
    trig = 4'b0001; run(12);
    trig = 4'b0000; run(6);
    trig = 4'b0001; step();
    trig = 4'b0000; run(5);
    cfg(0, 2, 0, 3, 0);
    trig = 4'b0001; run(10);
    trig = 4'b0000; run(5);

    // Gate, width=4: long trigger then short trigger.
    cfg(0, 3, 0, 4, 0);
    trig = 4'b0001; run(10);
    trig = 4'b0000; run(3);
    trig = 4'b0001; run(2);
    trig = 4'b0000; run(3);

    // All channels on the same edge, reset mid-sequence.
    cfg(0, 0, 2, 3, 0);
    cfg(1, 1, 0, 4, 0);
    cfg(2, 2, 1, 2, 1);
    cfg(3, 3, 0, 5, 0);
    trig = 4'b1111; run(4);
    rst_n = 1'b0; step();
    chk("mid_rst_pulse", pulse, 4'b0000);
    chk("mid_rst_busy", busy, 4'b0000);
    rst_n = 1'b1; run(3);
    trig = 4'b0000; run(2);

    // Random traffic; config inputs change every cycle to exercise latching.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        if ($urandom_range(0, 3) == 0) trig[c] = ~trig[c];
      end
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
